// File: rtl/riscv_perf_pkg.sv
// Shared constants for the RISC-V run-control / performance monitor.
// State encoding, default halt instruction and default counter width.
package riscv_perf_pkg;

    localparam int PERF_CNT_W = 16;

    localparam logic [31:0] PERF_HALT_INSTR = 32'h0010_0073;

    typedef enum logic [1:0] {
        PS_IDLE = 2'd0,
        PS_RUN  = 2'd1,
        PS_DONE = 2'd2
    } perf_state_e;

endpackage

// File: rtl/riscv_perf_monitor_counter.sv
// Saturating up-counter: async reset, sync clear, increment enable.
// sat_hit flags an increment attempted while already at all-ones.
module perf_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         sat_hit
);

    logic at_max;

    assign at_max  = &count;
    assign sat_hit = inc && at_max;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !at_max) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/riscv_perf_monitor.sv
// Run control, halt detection and cycle/instruction counting for the core.
// Optional watchdog compiled in with `define PERF_WATCHDOG_EN.
module riscv_perf_monitor
    import riscv_perf_pkg::*;
#(
    parameter int          CNT_W           = PERF_CNT_W,
    parameter logic [31:0] HALT_INSTR      = PERF_HALT_INSTR,
    parameter int          WATCHDOG_CYCLES = 1000
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic             start,
    input  logic             retire,
    input  logic [31:0]      retire_instr,
    output logic             done,
    output logic [CNT_W-1:0] clock_count,
    output logic [CNT_W-1:0] instr_cnt,
    output logic             cnt_ovf,
    output logic             timeout
);

    perf_state_e state, state_nxt;

    logic halt;
    logic wd_fire;
    logic run_edge;
    logic restart;
    logic sat_clk;
    logic sat_ins;
    logic done_r;
    logic ovf_r;

    assign halt     = retire && (retire_instr == HALT_INSTR);
    assign run_edge = (state == PS_RUN) && !wd_fire;
    assign restart  = start && (state != PS_RUN);

`ifdef PERF_WATCHDOG_EN
    logic timeout_r;

    assign wd_fire = (state == PS_RUN) && !halt &&
                     (32'(clock_count) == 32'(WATCHDOG_CYCLES));

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            timeout_r <= 1'b0;
        end else if (restart) begin
            timeout_r <= 1'b0;
        end else if (wd_fire) begin
            timeout_r <= 1'b1;
        end
    end

    assign timeout = timeout_r;
`else
    // Watchdog compiled out: the limit is unused and never fires.
    assign wd_fire = (WATCHDOG_CYCLES < 0);
    assign timeout = 1'b0;
`endif

    perf_sat_counter #(.W(CNT_W)) u_clk_cnt (
        .clk     (CLOCK_50),
        .rst     (reset),
        .clr     (restart),
        .inc     (run_edge),
        .count   (clock_count),
        .sat_hit (sat_clk)
    );

    perf_sat_counter #(.W(CNT_W)) u_ins_cnt (
        .clk     (CLOCK_50),
        .rst     (reset),
        .clr     (restart),
        .inc     (run_edge && retire),
        .count   (instr_cnt),
        .sat_hit (sat_ins)
    );

    always_comb begin
        state_nxt = state;
        unique case (state)
            PS_IDLE: if (start)           state_nxt = PS_RUN;
            PS_RUN:  if (halt || wd_fire) state_nxt = PS_DONE;
            PS_DONE: if (start)           state_nxt = PS_RUN;
            default:                      state_nxt = PS_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state  <= PS_IDLE;
            done_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_r <= (state_nxt == PS_DONE);
            if (restart) begin
                ovf_r <= 1'b0;
            end else if (sat_clk || sat_ins) begin
                ovf_r <= 1'b1;
            end
        end
    end

    assign done    = done_r;
    assign cnt_ovf = ovf_r;

endmodule
